coins_to_num: RTL and testbench

COINS_TO_NUM -- requirements
Module: coins_to_num

---
 rtl/coins_to_num.sv | 83 ++++++++
 tb/tb_coins_to_num.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/coins_to_num.sv
// coins_to_num: coin credit accumulator with per-denomination counts, reject pulse and freeze-for-read handshake.
// Define COINS_TO_NUM_DOLLAR_EN to accept dollar coins (coin_type 3); otherwise they are always rejected.
module coins_to_num #(
   parameter int MAX_CENTS = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        coin_valid,
   input  logic [1:0]  coin_type,
   output logic        coin_ready,
   input  logic        clear,
   input  logic        rd_req,
   output logic        rd_ack,
   output logic [8:0]  total,
   output logic [13:0] coins,
   output logic        reject
);
   typedef enum logic [1:0] {IDLE, ACCUM, FULL, HOLD} state_t;
   localparam logic [9:0] MAX = 10'(MAX_CENTS);
   state_t state, next;
   logic [3:0] cnt_n, cnt_d, cnt_q, cnt_o, cnt_sel;
   logic [9:0] val, sum;
   logic type_ok, accept, clr;

   function automatic state_t level(input logic [9:0] t);
      return t == 10'd0 ? IDLE : t == MAX ? FULL : ACCUM;
   endfunction

   // 10-bit sum so total+100 cannot wrap before the ceiling compare
   always_comb begin
      val = coin_type == 2'd0 ? 10'd5 : coin_type == 2'd1 ? 10'd10 : coin_type == 2'd2 ? 10'd25 : 10'd100;
      cnt_sel = coin_type == 2'd0 ? cnt_n : coin_type == 2'd1 ? cnt_d : coin_type == 2'd2 ? cnt_q : cnt_o;
      sum = {1'b0, total} + val;
      clr = clear && state != HOLD;
      accept = coin_valid && coin_ready && type_ok && sum <= MAX && cnt_sel < 4'd9;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next;

   always_comb
      next = rd_req ? HOLD : clr ? IDLE : accept ? level(sum) : level({1'b0, total});

   always_comb begin
      coin_ready = (state == IDLE || state == ACCUM) && !clear;
      rd_ack = state == HOLD;
      coins = 14'(cnt_o) * 14'd1000 + 14'(cnt_q) * 14'd100 + 14'(cnt_d) * 14'd10 + 14'(cnt_n);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         total <= '0;
         cnt_n <= '0;
         cnt_d <= '0;
         cnt_q <= '0;
         reject <= 1'b0;
      end else begin
         reject <= coin_valid && !accept;
         if (clr) begin
            total <= '0;
            cnt_n <= '0;
            cnt_d <= '0;
            cnt_q <= '0;
         end else if (accept) begin
            total <= sum[8:0];
            cnt_n <= cnt_n + 4'(coin_type == 2'd0);
            cnt_d <= cnt_d + 4'(coin_type == 2'd1);
            cnt_q <= cnt_q + 4'(coin_type == 2'd2);
         end
      end

`ifdef COINS_TO_NUM_DOLLAR_EN
   assign type_ok = 1'b1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_o <= '0;
      else if (clr) cnt_o <= '0;
      else if (accept && coin_type == 2'd3) cnt_o <= cnt_o + 4'd1;
`else
   assign type_ok = coin_type != 2'd3;
   assign cnt_o = 4'd0;
`endif
endmodule

// File: tb/tb_coins_to_num.sv
// tb_coins_to_num: directed and randomized check of coins_to_num against a cents/count model.
module tb_coins_to_num;
`ifdef COINS_TO_NUM_DOLLAR_EN
   localparam int MAX = 500;
   localparam bit DOL = 1'b1;
`else
   localparam int MAX = 100;
   localparam bit DOL = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0, coin_valid = 1'b0, clear = 1'b0, rd_req = 1'b0;
   logic [1:0] coin_type = 2'd0;
   logic coin_ready, rd_ack, reject;
   logic [8:0] total;
   logic [13:0] coins;
   int checks = 0, failures = 0;
   bit chk_en = 1'b0;
   int m_total;
   int m_cnt[4];
   bit m_hold, m_rej;
   int worth[4] = '{5, 10, 25, 100};

   coins_to_num #(.MAX_CENTS(MAX)) dut (
      .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_type(coin_type),
      .coin_ready(coin_ready), .clear(clear), .rd_req(rd_req), .rd_ack(rd_ack),
      .total(total), .coins(coins), .reject(reject)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_coins();
      return m_cnt[3] * 1000 + m_cnt[2] * 100 + m_cnt[1] * 10 + m_cnt[0];
   endfunction

   task automatic model_reset();
      m_total = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_hold = 1'b0;
      m_rej = 1'b0;
   endtask

   always @(negedge clk)
      if (chk_en) begin
         cmp("total", int'(total), m_total);
         cmp("coins", int'(coins), m_coins());
         cmp("rd_ack", int'(rd_ack), int'(m_hold));
         cmp("reject", int'(reject), int'(m_rej));
         cmp("coin_ready", int'(coin_ready), int'(!m_hold && m_total < MAX && !clear));
      end

   task automatic drive(input bit cv, input int ct, input bit cl, input bit rq);
      coin_valid = cv;
      coin_type = 2'(ct);
      clear = cl;
      rd_req = rq;
   endtask

   task automatic tick();
      int v;
      bit ready, acc;
      @(posedge clk);
      v = worth[coin_type];
      ready = !m_hold && m_total < MAX && !clear;
      acc = coin_valid && ready && (DOL || coin_type != 2'd3) && m_total + v <= MAX && m_cnt[coin_type] < 9;
      m_rej = coin_valid && !acc;
      if (clear && !m_hold) begin
         m_total = 0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end else if (acc) begin
         m_total += v;
         m_cnt[coin_type]++;
      end
      m_hold = rd_req;
      #1;
   endtask

   task automatic cyc(input bit cv, input int ct, input bit cl, input bit rq);
      drive(cv, ct, cl, rq);
      tick();
   endtask

   task automatic async_reset();
      drive(0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      cmp("rst_total", int'(total), 0);
      cmp("rst_coins", int'(coins), 0);
      cmp("rst_rd_ack", int'(rd_ack), 0);
      cmp("rst_reject", int'(reject), 0);
      cmp("rst_ready", int'(coin_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit rq;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      cmp("init_total", int'(total), 0);
      cmp("init_ready", int'(coin_ready), 1);
      // quarter, dime, nickel
      cyc(1, 2, 0, 0);
      cmp("qdn_25", int'(total), 25);
      cyc(1, 1, 0, 0);
      cmp("qdn_35", int'(total), 35);
      cyc(1, 0, 0, 0);
      cmp("qdn_40", int'(total), 40);
      cmp("qdn_coins", int'(coins), 111);
      cmp("qdn_reject", int'(reject), 0);
      // ten nickels, tenth hits the count cap
      cyc(0, 0, 1, 0);
      repeat (10) cyc(1, 0, 0, 0);
      cmp("nick_reject", int'(reject), 1);
      cmp("nick_total", int'(total), 45);
      cmp("nick_coins", int'(coins), 9);
      // clear with a coin in the same cycle
      cyc(0, 0, 1, 0);
      cyc(1, 2, 0, 0);
      cyc(1, 1, 0, 0);
      cmp("clr_pre", int'(total), 35);
      drive(1, 1, 1, 0);
      #1;
      cmp("clr_ready", int'(coin_ready), 0);
      tick();
      cmp("clr_total", int'(total), 0);
      cmp("clr_reject", int'(reject), 1);
      drive(0, 0, 0, 0);
      #1;
      cmp("clr_idle_ready", int'(coin_ready), 1);
      // read hold ignores coins and clear
      cyc(1, 2, 0, 0);
      cyc(0, 0, 0, 1);
      cmp("hold_ack", int'(rd_ack), 1);
      repeat (3) cyc(1, $urandom_range(3), 1, 1);
      cmp("hold_ack3", int'(rd_ack), 1);
      cmp("hold_reject", int'(reject), 1);
      cmp("hold_total", int'(total), 25);
      cyc(0, 0, 0, 0);
      cmp("hold_release", int'(rd_ack), 0);
      cmp("hold_after_total", int'(total), 25);
      cyc(0, 0, 1, 0);
`ifdef COINS_TO_NUM_DOLLAR_EN
      repeat (5) cyc(1, 3, 0, 0);
      cmp("dol_total", int'(total), 500);
      cmp("dol_coins", int'(coins), 5000);
      drive(0, 0, 0, 0);
      #1;
      cmp("dol_full_ready", int'(coin_ready), 0);
      cyc(1, 0, 0, 0);
      cmp("dol_reject", int'(reject), 1);
      cmp("dol_stay", int'(total), 500);
`else
      cyc(1, 3, 0, 0);
      cmp("nodol_reject", int'(reject), 1);
      cmp("nodol_total", int'(total), 0);
      repeat (4) cyc(1, 2, 0, 0);
      cmp("full_total", int'(total), 100);
      drive(0, 0, 0, 0);
      #1;
      cmp("full_ready", int'(coin_ready), 0);
      cyc(1, 0, 0, 0);
      cmp("full_reject", int'(reject), 1);
`endif
      // asynchronous reset in the middle of a read
      cyc(0, 0, 1, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 1);
      async_reset();
      rq = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(9) == 0) rq = !rq;
         cyc($urandom_range(99) < 60, $urandom_range(3), $urandom_range(19) == 0, rq);
         if (i == 1500) async_reset();
      end
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
